// File: rtl/dit_butterfly_round.sv
// rtl/dit_butterfly_round.sv - radix-2 DIT butterfly combine: add/sub, half-up round, clamp or wrap
// Optional feature macro: BFLY_SAT_EN (output clamping plus sticky saturation flag/counter).
module dit_butterfly_round #(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int OUT_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic signed [DATA_WIDTH+TWID_WIDTH:0] x0_r,
  input  logic signed [DATA_WIDTH+TWID_WIDTH:0] x0_i,
  input  logic signed [DATA_WIDTH+TWID_WIDTH:0] x1w_r,
  input  logic signed [DATA_WIDTH+TWID_WIDTH:0] x1w_i,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic signed [OUT_WIDTH-1:0]          y0_r,
  output logic signed [OUT_WIDTH-1:0]          y0_i,
  output logic signed [OUT_WIDTH-1:0]          y1_r,
  output logic signed [OUT_WIDTH-1:0]          y1_i,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 sat_flag,
  output logic [15:0]                          sat_count,
  input  logic                                 sat_clr
);
  localparam int W  = DATA_WIDTH + TWID_WIDTH + 1;
  localparam int RW = W + 2 - SHIFT;
  localparam logic signed [W+1:0] HALF = (W+2)'(1) << (SHIFT - 1);

  // lane order in every stage array: 0=y0_r, 1=y0_i, 2=y1_r, 3=y1_i
  logic              r_v1, r_v2, r_v3;
  logic signed [W:0] r_s1 [4];
  logic [RW-1:0]     r_s2 [4];
  logic [OUT_WIDTH-1:0] r_y [4];

  logic              w_en1, w_en2, w_en3;
  logic signed [W:0] w_x0_r, w_x0_i, w_x1_r, w_x1_i;
  logic [W+1:0]      w_rsum [4];
  logic [RW-1:0]     w_rnd [4];
  logic [OUT_WIDTH-1:0] w_y [4];
  logic              w_unused_round;

  assign w_en3    = !r_v3 || out_ready;
  assign w_en2    = !r_v2 || w_en3;
  assign w_en1    = !r_v1 || w_en2;
  assign in_ready = w_en1;

  assign w_x0_r = {x0_r[W-1], x0_r};
  assign w_x0_i = {x0_i[W-1], x0_i};
  assign w_x1_r = {x1w_r[W-1], x1w_r};
  assign w_x1_i = {x1w_i[W-1], x1w_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      for (int k = 0; k < 4; k++) r_s1[k] <= '0;
    end else if (w_en1) begin
      r_v1    <= in_valid;
      r_s1[0] <= w_x0_r + w_x1_r;
      r_s1[1] <= w_x0_i + w_x1_i;
      r_s1[2] <= w_x0_r - w_x1_r;
      r_s1[3] <= w_x0_i - w_x1_i;
    end
  end

  // Extra guard bit keeps the rounding offset from overflowing; the upper slice is the arithmetic shift.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_rsum[k] = {r_s1[k][W], r_s1[k]} + HALF;
      w_rnd[k]  = w_rsum[k][W+1:SHIFT];
    end
  end
  assign w_unused_round = ^{w_rsum[0][SHIFT-1:0], w_rsum[1][SHIFT-1:0],
                            w_rsum[2][SHIFT-1:0], w_rsum[3][SHIFT-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      for (int k = 0; k < 4; k++) r_s2[k] <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      for (int k = 0; k < 4; k++) r_s2[k] <= w_rnd[k];
    end
  end

`ifdef BFLY_SAT_EN
  logic        w_sat;
  logic        w_sat_beat;
  logic        r_sat3;
  logic        r_sat_flag;
  logic [15:0] r_sat_count;

  // In range exactly when every bit above the output sign bit matches it.
  always_comb begin
    w_sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_y[k] = r_s2[k][OUT_WIDTH-1:0];
      if (!((&r_s2[k][RW-1:OUT_WIDTH-1]) || !(|r_s2[k][RW-1:OUT_WIDTH-1]))) begin
        w_sat  = 1'b1;
        w_y[k] = r_s2[k][RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

  assign w_sat_beat = r_v3 && out_ready && r_sat3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_flag  <= 1'b0;
      r_sat_count <= 16'd0;
    end else if (sat_clr) begin
      r_sat_flag  <= w_sat_beat;
      r_sat_count <= {15'd0, w_sat_beat};
    end else if (w_sat_beat) begin
      r_sat_flag <= 1'b1;
      if (r_sat_count != 16'hFFFF) r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_flag  = r_sat_flag;
  assign sat_count = r_sat_count;
`else
  logic w_unused_trunc;

  always_comb begin
    for (int k = 0; k < 4; k++) w_y[k] = r_s2[k][OUT_WIDTH-1:0];
  end

  assign w_unused_trunc = ^{sat_clr, r_s2[0][RW-1:OUT_WIDTH], r_s2[1][RW-1:OUT_WIDTH],
                            r_s2[2][RW-1:OUT_WIDTH], r_s2[3][RW-1:OUT_WIDTH]};
  assign sat_flag  = 1'b0;
  assign sat_count = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v3 <= 1'b0;
      for (int k = 0; k < 4; k++) r_y[k] <= '0;
`ifdef BFLY_SAT_EN
      r_sat3 <= 1'b0;
`endif
    end else if (w_en3) begin
      r_v3 <= r_v2;
      for (int k = 0; k < 4; k++) r_y[k] <= w_y[k];
`ifdef BFLY_SAT_EN
      r_sat3 <= w_sat;
`endif
    end
  end

  assign out_valid = r_v3;
  assign y0_r      = r_y[0];
  assign y0_i      = r_y[1];
  assign y1_r      = r_y[2];
  assign y1_i      = r_y[3];
endmodule

// File: tb/tb_dit_butterfly_round.sv
// tb/tb_dit_butterfly_round.sv - randomized and directed bench for dit_butterfly_round
// Expectations follow BFLY_SAT_EN: clamped with counters when defined, two's-complement wrap otherwise.
module tb_dit_butterfly_round;
  localparam int W  = 38;
  localparam int OW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, sat_clr;
  logic signed [W-1:0] x0_r, x0_i, x1w_r, x1w_i;
  logic in_ready, out_valid, sat_flag;
  logic signed [OW-1:0] y0_r, y0_i, y1_r, y1_i;
  logic [15:0] sat_count;

  dit_butterfly_round dut (
    .clk(clk), .rst_n(rst_n),
    .x0_r(x0_r), .x0_i(x0_i), .x1w_r(x1w_r), .x1w_i(x1w_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  typedef struct {
    longint y0r, y0i, y1r, y1i;
    bit     sat;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  got_q[$];
  int     total, bad;
  bit     m_flag;
  int     m_cnt;

  // Reference: round half-up of (sum / 2^15), then clamp to 22-bit range or wrap.
  function automatic longint fix(input longint s, output bit c);
    longint r;
    r = (s + 64'sd16384) >>> 15;
    c = 1'b0;
`ifdef BFLY_SAT_EN
    if (r > 64'sd2097151) begin r = 64'sd2097151; c = 1'b1; end
    else if (r < -64'sd2097152) begin r = -64'sd2097152; c = 1'b1; end
`else
    r = (r <<< 42) >>> 42;
`endif
    return r;
  endfunction

  function automatic beat_t model(input longint a, input longint b, input longint c, input longint d);
    beat_t e;
    bit c0, c1, c2, c3;
    e.y0r = fix(a + c, c0);
    e.y0i = fix(b + d, c1);
    e.y1r = fix(a - c, c2);
    e.y1i = fix(b - d, c3);
    e.sat = c0 | c1 | c2 | c3;
    return e;
  endfunction

  function automatic longint rnd_big();
    longint v;
    v = {$urandom, $urandom};
    return (v <<< 26) >>> 26;
  endfunction

  function automatic longint rnd_small();
    return longint'($signed($urandom)) >>> 4;
  endfunction

  // One cycle: drive at negedge, observe handshakes just after, record transfers and track sat stats.
  task automatic step(input bit iv, input bit ordy, input bit clr,
                      input longint a, input longint b, input longint c, input longint d);
    beat_t g;
    bit    beat, bs;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    sat_clr   = clr;
    x0_r = a[W-1:0]; x0_i = b[W-1:0]; x1w_r = c[W-1:0]; x1w_i = d[W-1:0];
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(a, b, c, d));
    beat = out_valid && out_ready;
    bs   = 1'b0;
    if (beat && got_q.size() < exp_q.size()) bs = exp_q[got_q.size()].sat;
    if (clr) begin
      m_flag = bs;
      m_cnt  = bs ? 1 : 0;
    end else if (bs) begin
      m_flag = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (beat) begin
      g.y0r = longint'(y0_r); g.y0i = longint'(y0_i);
      g.y1r = longint'(y1_r); g.y1i = longint'(y1_i);
      g.sat = 1'b0;
      got_q.push_back(g);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if ({y0_r, y0_i, y1_r, y1_i} !== '0) begin
      bad++; $display("FAIL reset_y got=%0d/%0d/%0d/%0d want=0", y0_r, y0_i, y1_r, y1_i);
    end
    total++;
    if (sat_flag !== 1'b0 || sat_count !== 16'd0) begin
      bad++; $display("FAIL reset_sat got=%b/%0d want=0/0", sat_flag, sat_count);
    end
    rst_n = 1'b1;
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    exp_q.delete(); got_q.delete(); m_flag = 0; m_cnt = 0;
  endtask

  task automatic test_basic();
    exp_q.delete(); got_q.delete();
    step(1, 1, 0, 64'sd100 <<< 15, 0, 64'sd50 <<< 15, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL basic_early got=%0d beats want=0", got_q.size()); end
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL basic_latency got=%0d beats want=1", got_q.size()); end
    else begin
      total++;
      if (got_q[0].y0r != 150 || got_q[0].y1r != 50 || got_q[0].y0i != 0 || got_q[0].y1i != 0) begin
        bad++;
        $display("FAIL basic_values got=%0d/%0d/%0d/%0d want=150/0/50/0",
                 got_q[0].y0r, got_q[0].y0i, got_q[0].y1r, got_q[0].y1i);
      end
    end
    step(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_round();
    exp_q.delete(); got_q.delete();
    step(1, 1, 0, 16384, 0, 0, 0);
    step(1, 1, 0, -16384, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL round_count got=%0d want=2", got_q.size()); end
    else begin
      total++;
      if (got_q[0].y0r != 1 || got_q[0].y1r != 1) begin
        bad++; $display("FAIL round_half_up got=%0d/%0d want=1/1", got_q[0].y0r, got_q[0].y1r);
      end
      total++;
      if (got_q[1].y0r != 0 || got_q[1].y1r != 0) begin
        bad++; $display("FAIL round_neg_half got=%0d/%0d want=0/0", got_q[1].y0r, got_q[1].y1r);
      end
    end
  endtask

  task automatic test_sat();
    longint a, ni, e_pos, e_neg;
    bit     e_f;
    int     e_c;
    a  = 64'sd1 <<< 35;
    ni = -((64'sd1 <<< 36) + (64'sd1 <<< 20));
`ifdef BFLY_SAT_EN
    e_pos = 2097151; e_neg = -2097152; e_f = 1; e_c = 1;
`else
    e_pos = -2097152; e_neg = 2097120; e_f = 0; e_c = 0;
`endif
    exp_q.delete(); got_q.delete();
    step(1, 1, 0, a, ni, a, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL sat_count_beats got=%0d want=1", got_q.size()); end
    else begin
      total++;
      if (got_q[0].y0r != e_pos || got_q[0].y1r != 0 || got_q[0].y0i != e_neg || got_q[0].y1i != e_neg) begin
        bad++;
        $display("FAIL sat_values got=%0d/%0d/%0d/%0d want=%0d/%0d/0/%0d",
                 got_q[0].y0r, got_q[0].y0i, got_q[0].y1r, got_q[0].y1i, e_pos, e_neg, e_neg);
      end
    end
    total++;
    if (sat_flag !== e_f || sat_count !== 16'(e_c)) begin
      bad++; $display("FAIL sat_stats got=%b/%0d want=%b/%0d", sat_flag, sat_count, e_f, e_c);
    end
    step(1, 1, 0, a, 0, a, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (sat_flag !== e_f || sat_count !== 16'(e_c)) begin
      bad++; $display("FAIL sat_clr_coincident got=%b/%0d want=%b/%0d", sat_flag, sat_count, e_f, e_c);
    end
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (sat_flag !== 1'b0 || sat_count !== 16'd0) begin
      bad++; $display("FAIL sat_clr_only got=%b/%0d want=0/0", sat_flag, sat_count);
    end
  endtask

  task automatic test_backpressure();
    longint s [5][4];
    int     idx, n, j;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 5; i++) for (int k = 0; k < 4; k++) s[i][k] = rnd_small();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      n = exp_q.size();
      j = (idx < 5) ? idx : 0;
      step(idx < 5, 0, 0, s[j][0], s[j][1], s[j][2], s[j][3]);
      if (exp_q.size() > n) idx++;
    end
    total++;
    if (idx != 3) begin bad++; $display("FAIL bp_accepts got=%0d want=3", idx); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++;
    if (out_valid !== 1'b1 || exp_q.size() == 0 || longint'(y0_r) != exp_q[0].y0r) begin
      bad++; $display("FAIL bp_hold got=%b/%0d want=1/first sample", out_valid, y0_r);
    end
    for (int c = 0; c < 20; c++) begin
      n = exp_q.size();
      j = (idx < 5) ? idx : 0;
      step(idx < 5, 1, 0, s[j][0], s[j][1], s[j][2], s[j][3]);
      if (exp_q.size() > n) idx++;
    end
    total++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      bad++; $display("FAIL bp_total got=%0d exp=%0d want=5", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i].y0r != exp_q[i].y0r || got_q[i].y0i != exp_q[i].y0i ||
          got_q[i].y1r != exp_q[i].y1r || got_q[i].y1i != exp_q[i].y1i) begin
        bad++;
        $display("FAIL bp_beat%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                 got_q[i].y0r, got_q[i].y0i, got_q[i].y1r, got_q[i].y1i,
                 exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_q.delete(); got_q.delete();
    step(1, 1, 0, rnd_small(), rnd_small(), rnd_small(), rnd_small());
    step(1, 1, 0, rnd_small(), rnd_small(), rnd_small(), rnd_small());
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    exp_q.delete(); m_flag = 0; m_cnt = 0;
    repeat (8) step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL rst_mid_leak got=%0d beats want=0", got_q.size()); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_random();
    longint v [4];
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) v[k] = ($urandom_range(0, 3) == 0) ? rnd_big() : rnd_small();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           v[0], v[1], v[2], v[3]);
    end
    repeat (10) step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i].y0r != exp_q[i].y0r || got_q[i].y0i != exp_q[i].y0i ||
          got_q[i].y1r != exp_q[i].y1r || got_q[i].y1i != exp_q[i].y1i) begin
        bad++;
        $display("FAIL rand_beat%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                 got_q[i].y0r, got_q[i].y0i, got_q[i].y1r, got_q[i].y1i,
                 exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i);
      end
    end
    total++;
    if (sat_flag !== m_flag || sat_count !== 16'(m_cnt)) begin
      bad++; $display("FAIL rand_sat_stats got=%b/%0d want=%b/%0d", sat_flag, sat_count, m_flag, m_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    x0_r = '0; x0_i = '0; x1w_r = '0; x1w_i = '0;
    total = 0; bad = 0; m_flag = 1'b0; m_cnt = 0;
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dit_butterfly_round.md
DIT_BUTTERFLY_ROUND -- requirements
Module: dit_butterfly_round

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 21, input sample width before twiddle multiply.
REQ-002 SHALL have parameter TWID_WIDTH, default 16, twiddle width.
REQ-003 SHALL have parameter SHIFT, default 15, twiddle fractional bits; legal range is SHIFT >= 1.
REQ-004 SHALL have parameter OUT_WIDTH, default DATA_WIDTH+1, output sample width; W denotes DATA_WIDTH+TWID_WIDTH+1.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset, synchronous and active-low.
REQ-007 SHALL have ports x0_r and x0_i, inputs, W bits each, signed, the pre-shifted X0 path (X0 << SHIFT).
REQ-008 SHALL have ports x1w_r and x1w_i, inputs, W bits each, signed, the X1*W product path.
REQ-009 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), the input handshake.
REQ-010 SHALL have ports y0_r, y0_i, y1_r and y1_i, outputs, OUT_WIDTH bits each, signed, giving Y0 = X0+X1W and Y1 = X0-X1W.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), the output handshake.
REQ-012 SHALL have port sat_flag, output, 1 bit, sticky saturation indicator.
REQ-013 SHALL have port sat_count, output, 16 bits, count of saturated output beats.
REQ-014 SHALL have port sat_clr, input, 1 bit, clears sat_flag and sat_count.

Function
REQ-015 A transfer SHALL occur on a rising edge where valid and ready are both high, at the input and at the output independently.
REQ-016 The datapath SHALL be three registered stages, S1 add/sub, S2 round, S3 saturate/output, each with its own valid bit.
REQ-017 S1 SHALL compute sums and differences at W+1 bits with sign extension, so the add/sub itself never overflows.
REQ-018 S2 SHALL round half-up: add 2^(SHIFT-1), then arithmetic-shift right by SHIFT.
REQ-019 S3 SHALL clamp each component to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-020 A stage SHALL load when it is empty or when its contents advance in the same cycle, collapsing bubbles.
REQ-021 in_ready SHALL equal (!S1 valid) OR S1 advancing, computed combinationally from out_ready and the stage valids.
REQ-022 With out_ready held high, latency SHALL be 3 cycles and throughput 1 sample per cycle.
REQ-023 With out_ready low, outputs SHALL hold stable; after 3 accepted samples in_ready SHALL be low until out_ready rises.
REQ-024 A saturated beat is an output transfer in which any of the four components was clamped.
REQ-025 On a saturated beat, sat_flag SHALL set and sat_count SHALL increment, holding at 65535 rather than wrapping.
REQ-026 sat_clr SHALL zero both sat_flag and sat_count; if a saturated beat occurs in the same cycle, the result SHALL be sat_flag=1 and sat_count=1.

Reset
REQ-027 While rst_n=0 at a clock edge, all stage valids, out_valid, y0_r, y0_i, y1_r, y1_i, sat_flag and sat_count SHALL become 0.
REQ-028 in_ready SHALL be 1 from the first cycle after reset releases.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples; no output beat is produced for them.

Configuration
REQ-030 With macro BFLY_SAT_EN defined, S3 SHALL clamp per REQ-019 and the saturation counters SHALL operate.
REQ-031 Without BFLY_SAT_EN, S3 SHALL truncate to OUT_WIDTH LSBs (two's-complement wrap), sat_flag and sat_count SHALL be constant 0, and sat_clr SHALL be ignored.

Verification (defaults; BFLY_SAT_EN defined unless stated)
REQ-032 x0_r=100<<15, x1w_r=50<<15, imaginary parts 0, out_ready=1 -> 3 cycles later y0_r=150, y1_r=50, y0_i=y1_i=0.
REQ-033 x0_r=2^14, x1w_r=0 -> y0_r=1 and y1_r=1 (half-up); x0_r=-(2^14), x1w_r=0 -> y0_r=0.
REQ-034 x0_r=2^35, x1w_r=2^35 -> y0_r=2097151, y1_r=0, sat_flag=1, sat_count=1; same stimulus without BFLY_SAT_EN -> y0_r=-2097152, sat_flag=0.
REQ-035 Offer 5 back-to-back samples with out_ready=0 -> in_ready falls after the 3rd accept; raise out_ready -> all 5 emerge in order with no loss or duplication.
REQ-036 Hold rst_n=0 for 1 cycle while 2 samples are in flight -> out_valid=0 next cycle and none of those samples ever appears; sat_clr coinciding with a saturated beat -> sat_count=1.
